// File: rtl/sync_fifo_flags_if.sv
// rtl/sync_fifo_flags_if.sv - producer/consumer bundle for the flagged single-clock FIFO
interface sync_fifo_flags_if #(
  parameter int FIFO_width   = 8,
  parameter int Pointer_Size = 3
);
  logic                    FLUSH;
  logic                    WR_INC;
  logic [FIFO_width-1:0]   WR_DATA;
  logic                    RD_INC;
  logic [FIFO_width-1:0]   RD_DATA;
  logic                    RD_VALID;
  logic                    FULL;
  logic                    EMPTY;
  logic                    ALMOST_FULL;
  logic                    ALMOST_EMPTY;
  logic [Pointer_Size:0]   COUNT;
  logic                    OVERFLOW;
  logic                    UNDERFLOW;

  modport master (
    output FLUSH, WR_INC, WR_DATA, RD_INC,
    input  RD_DATA, RD_VALID, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY,
           COUNT, OVERFLOW, UNDERFLOW
  );

  modport slave (
    input  FLUSH, WR_INC, WR_DATA, RD_INC,
    output RD_DATA, RD_VALID, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY,
           COUNT, OVERFLOW, UNDERFLOW
  );
endinterface

// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - single-clock FIFO with count, thresholds, error pulses, flush, FWFT option
module sync_fifo_flags #(
  parameter int FIFO_width   = 8,
  parameter int FIFO_depth   = 8,
  parameter int Pointer_Size = 3,
  parameter int AF_LEVEL     = 6,
  parameter int AE_LEVEL     = 2,
  parameter int FWFT         = 0
) (
  input  logic                 CLK,
  input  logic                 RST,
  sync_fifo_flags_if.slave     bus
);
  localparam int CW = Pointer_Size + 1;
  localparam logic [CW-1:0]           DEPTH_C = CW'(FIFO_depth);
  localparam logic [CW-1:0]           AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0]           AE_C    = CW'(AE_LEVEL);
  localparam logic [CW-1:0]           CNT_ONE = CW'(1);
  localparam logic [Pointer_Size-1:0] PTR_ONE = Pointer_Size'(1);

  logic [FIFO_width-1:0]   mem [FIFO_depth];
  logic [Pointer_Size-1:0] wr_ptr;
  logic [Pointer_Size-1:0] rd_ptr;
  logic [CW-1:0]           count_q;
  logic [CW-1:0]           count_nxt;
  logic                    full_q;
  logic                    empty_q;
  logic                    af_q;
  logic                    ae_q;
  logic                    ovf_q;
  logic                    udf_q;
  logic                    rd_valid_q;
  logic [FIFO_width-1:0]   rd_data_q;
  logic                    wr_acc;
  logic                    rd_acc;

  // Acceptance uses the flags registered at the start of the cycle; flush suppresses both sides.
  always_comb begin
    wr_acc    = bus.WR_INC & ~full_q  & ~bus.FLUSH;
    rd_acc    = bus.RD_INC & ~empty_q & ~bus.FLUSH;
    count_nxt = count_q;
    if (bus.FLUSH) begin
      count_nxt = '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   count_nxt = count_q + CNT_ONE;
        2'b01:   count_nxt = count_q - CNT_ONE;
        default: count_nxt = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      if (bus.FLUSH) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
        if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
      end
      count_q <= count_nxt;
      full_q  <= (count_nxt == DEPTH_C);
      empty_q <= (count_nxt == '0);
      af_q    <= (count_nxt >= AF_C);
      ae_q    <= (count_nxt <= AE_C);
      ovf_q   <= bus.WR_INC & full_q  & ~bus.FLUSH;
      udf_q   <= bus.RD_INC & empty_q & ~bus.FLUSH;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge CLK) begin
    if (wr_acc) mem[wr_ptr] <= bus.WR_DATA;
  end

  // Registered-read path; flush drops the valid but keeps the last word on the bus.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else if (bus.FLUSH) begin
      rd_valid_q <= 1'b0;
    end else if (rd_acc) begin
      rd_valid_q <= 1'b1;
      rd_data_q  <= mem[rd_ptr];
    end else begin
      rd_valid_q <= 1'b0;
    end
  end

  assign bus.RD_DATA      = (FWFT != 0) ? mem[rd_ptr] : rd_data_q;
  assign bus.RD_VALID     = (FWFT != 0) ? ~empty_q    : rd_valid_q;
  assign bus.FULL         = full_q;
  assign bus.EMPTY        = empty_q;
  assign bus.ALMOST_FULL  = af_q;
  assign bus.ALMOST_EMPTY = ae_q;
  assign bus.COUNT        = count_q;
  assign bus.OVERFLOW     = ovf_q;
  assign bus.UNDERFLOW    = udf_q;
endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb/tb_sync_fifo_flags.sv - randomized queue-model bench for sync_fifo_flags in both read modes
module tb_sync_fifo_flags;
  logic       clk;
  logic       rst;
  logic       flush;
  logic       wr;
  logic [7:0] wd;
  logic       rd;

  sync_fifo_flags_if #(.FIFO_width(8), .Pointer_Size(3)) b0 ();
  sync_fifo_flags_if #(.FIFO_width(8), .Pointer_Size(3)) b1 ();

  assign b0.FLUSH = flush;  assign b1.FLUSH = flush;
  assign b0.WR_INC = wr;    assign b1.WR_INC = wr;
  assign b0.WR_DATA = wd;   assign b1.WR_DATA = wd;
  assign b0.RD_INC = rd;    assign b1.RD_INC = rd;

  sync_fifo_flags #(.FIFO_width(8), .FIFO_depth(8), .Pointer_Size(3), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0))
    u_reg (.CLK(clk), .RST(rst), .bus(b0));
  sync_fifo_flags #(.FIFO_width(8), .FIFO_depth(8), .Pointer_Size(3), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1))
    u_fwft (.CLK(clk), .RST(rst), .bus(b1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: a plain queue of words plus the registered-read output and error pulses.
  logic [7:0] q[$];
  logic [7:0] m_rd0;
  logic       m_v0;
  logic       m_ovf;
  logic       m_udf;

  task automatic model_reset();
    q.delete();
    m_rd0 = 8'h00;
    m_v0  = 1'b0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  task automatic cycle(input logic f, input logic w, input logic [7:0] d, input logic r);
    int  sz;
    bit  was_full;
    bit  was_empty;
    flush = f; wr = w; wd = d; rd = r;
    @(posedge clk);
    sz        = q.size();
    was_full  = (sz == 8);
    was_empty = (sz == 0);
    if (f) begin
      q.delete();
      m_ovf = 1'b0; m_udf = 1'b0; m_v0 = 1'b0;
    end else begin
      m_ovf = w && was_full;
      m_udf = r && was_empty;
      if (r && !was_empty) begin
        m_rd0 = q.pop_front();
        m_v0  = 1'b1;
      end else begin
        m_v0 = 1'b0;
      end
      if (w && !was_full) q.push_back(d);
    end
    #1;
    flush = 1'b0; wr = 1'b0; rd = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; wr = 1'b0; rd = 1'b0; wd = 8'h00;
    #12;
    model_reset();
    checks++; if (b0.COUNT !== 4'd0)      begin errors++; $display("FAIL reset_count got=%0d exp=0", b0.COUNT); end
    checks++; if (b0.EMPTY !== 1'b1)      begin errors++; $display("FAIL reset_empty got=%b exp=1", b0.EMPTY); end
    checks++; if (b0.FULL !== 1'b0)       begin errors++; $display("FAIL reset_full got=%b exp=0", b0.FULL); end
    checks++; if (b0.ALMOST_FULL !== 1'b0) begin errors++; $display("FAIL reset_af got=%b exp=0", b0.ALMOST_FULL); end
    checks++; if (b0.ALMOST_EMPTY !== 1'b1) begin errors++; $display("FAIL reset_ae got=%b exp=1", b0.ALMOST_EMPTY); end
    checks++; if (b0.RD_VALID !== 1'b0 || b0.RD_DATA !== 8'h00) begin errors++; $display("FAIL reset_rd got=%b/%h exp=0/00", b0.RD_VALID, b0.RD_DATA); end
    checks++; if (b0.OVERFLOW !== 1'b0 || b0.UNDERFLOW !== 1'b0) begin errors++; $display("FAIL reset_err got=%b%b exp=00", b0.OVERFLOW, b0.UNDERFLOW); end
    checks++; if (b1.RD_VALID !== 1'b0)   begin errors++; $display("FAIL reset_fwft_valid got=%b exp=0", b1.RD_VALID); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, 8'(i + 1), 1'b0);
      checks++; if (b0.COUNT !== 4'(i + 1)) begin errors++; $display("FAIL fill_count got=%0d exp=%0d", b0.COUNT, i + 1); end
      checks++; if (b0.ALMOST_FULL !== (i + 1 >= 6)) begin errors++; $display("FAIL fill_af got=%b exp=%b", b0.ALMOST_FULL, (i + 1 >= 6)); end
      checks++; if (b0.FULL !== (i == 7)) begin errors++; $display("FAIL fill_full got=%b exp=%b", b0.FULL, (i == 7)); end
    end
    cycle(1'b0, 1'b1, 8'h99, 1'b0);
    checks++; if (b0.OVERFLOW !== 1'b1 || b0.COUNT !== 4'd8) begin errors++; $display("FAIL overflow got=%b/%0d exp=1/8", b0.OVERFLOW, b0.COUNT); end
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    checks++; if (b0.OVERFLOW !== 1'b0) begin errors++; $display("FAIL overflow_pulse got=%b exp=0", b0.OVERFLOW); end
  endtask

  task automatic test_drain_registered();
    for (int k = 0; k < 8; k++) begin
      cycle(1'b0, 1'b0, 8'h00, 1'b1);
      checks++; if (b0.RD_VALID !== 1'b1 || b0.RD_DATA !== 8'(k + 1)) begin errors++; $display("FAIL drain_data got=%b/%h exp=1/%h", b0.RD_VALID, b0.RD_DATA, 8'(k + 1)); end
      checks++; if (b0.ALMOST_EMPTY !== (7 - k <= 2)) begin errors++; $display("FAIL drain_ae got=%b exp=%b", b0.ALMOST_EMPTY, (7 - k <= 2)); end
      checks++; if (b0.EMPTY !== (k == 7)) begin errors++; $display("FAIL drain_empty got=%b exp=%b", b0.EMPTY, (k == 7)); end
    end
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    checks++; if (b0.UNDERFLOW !== 1'b1 || b0.RD_VALID !== 1'b0) begin errors++; $display("FAIL underflow got=%b/%b exp=1/0", b0.UNDERFLOW, b0.RD_VALID); end
    checks++; if (b0.RD_DATA !== 8'h08) begin errors++; $display("FAIL underflow_hold got=%h exp=08", b0.RD_DATA); end
  endtask

  task automatic test_fwft();
    cycle(1'b0, 1'b1, 8'hA5, 1'b0);
    checks++; if (b1.EMPTY !== 1'b0 || b1.RD_VALID !== 1'b1 || b1.RD_DATA !== 8'hA5) begin errors++; $display("FAIL fwft_show got=%b/%b/%h exp=0/1/a5", b1.EMPTY, b1.RD_VALID, b1.RD_DATA); end
    checks++; if (b0.RD_VALID !== 1'b0) begin errors++; $display("FAIL reg_no_show got=%b exp=0", b0.RD_VALID); end
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    checks++; if (b1.EMPTY !== 1'b1 || b1.RD_VALID !== 1'b0) begin errors++; $display("FAIL fwft_pop got=%b/%b exp=1/0", b1.EMPTY, b1.RD_VALID); end
    checks++; if (b0.RD_VALID !== 1'b1 || b0.RD_DATA !== 8'hA5) begin errors++; $display("FAIL reg_pop got=%b/%h exp=1/a5", b0.RD_VALID, b0.RD_DATA); end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 8'($urandom), 1'b0);
    cycle(1'b0, 1'b1, 8'hFF, 1'b1);
    checks++; if (b0.OVERFLOW !== 1'b1 || b0.COUNT !== 4'd7) begin errors++; $display("FAIL full_both got=%b/%0d exp=1/7", b0.OVERFLOW, b0.COUNT); end
    checks++; if (b0.RD_DATA !== m_rd0) begin errors++; $display("FAIL full_both_data got=%h exp=%h", b0.RD_DATA, m_rd0); end
    for (int i = 0; i < 16 && q.size() != 0; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
    cycle(1'b0, 1'b1, 8'h3C, 1'b1);
    checks++; if (b0.COUNT !== 4'd1 || b0.UNDERFLOW !== 1'b1) begin errors++; $display("FAIL empty_both got=%0d/%b exp=1/1", b0.COUNT, b0.UNDERFLOW); end
    checks++; if (b1.RD_DATA !== 8'h3C) begin errors++; $display("FAIL empty_both_fwft got=%h exp=3c", b1.RD_DATA); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 16 && q.size() != 0; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 1'b1, 8'($urandom), (i % 2) == 1);
      checks++; if (b0.COUNT !== 4'(q.size())) begin errors++; $display("FAIL wrap_count got=%0d exp=%0d", b0.COUNT, q.size()); end
    end
    for (int i = 0; i < 16 && q.size() != 0; i++) begin
      if (b1.RD_DATA !== q[0]) begin checks++; errors++; $display("FAIL wrap_fwft got=%h exp=%h", b1.RD_DATA, q[0]); end else checks++;
      cycle(1'b0, 1'b0, 8'h00, 1'b1);
      checks++; if (b0.RD_DATA !== m_rd0 || b0.RD_VALID !== 1'b1) begin errors++; $display("FAIL wrap_order got=%h exp=%h", b0.RD_DATA, m_rd0); end
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b1, 8'($urandom), 1'b1);
      checks++; if (b0.COUNT !== 4'd4 || b0.RD_DATA !== m_rd0) begin errors++; $display("FAIL steady got=%0d/%h exp=4/%h", b0.COUNT, b0.RD_DATA, m_rd0); end
    end
  endtask

  task automatic test_flush();
    logic [7:0] held;
    for (int i = 0; i < 16 && q.size() != 5; i++) cycle(1'b0, q.size() < 5, 8'($urandom), q.size() > 5);
    held = m_rd0;
    cycle(1'b1, 1'b1, 8'h77, 1'b0);
    checks++; if (b0.COUNT !== 4'd0 || b0.EMPTY !== 1'b1 || b0.ALMOST_EMPTY !== 1'b1) begin errors++; $display("FAIL flush5 got=%0d/%b/%b exp=0/1/1", b0.COUNT, b0.EMPTY, b0.ALMOST_EMPTY); end
    checks++; if (b0.OVERFLOW !== 1'b0 || b0.RD_VALID !== 1'b0 || b0.RD_DATA !== held) begin errors++; $display("FAIL flush5_rd got=%b/%b/%h exp=0/0/%h", b0.OVERFLOW, b0.RD_VALID, b0.RD_DATA, held); end
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 8'($urandom), 1'b0);
    held = m_rd0;
    cycle(1'b1, 1'b1, 8'h55, 1'b1);
    checks++; if (b0.OVERFLOW !== 1'b0 || b0.FULL !== 1'b0 || b0.RD_VALID !== 1'b0 || b0.RD_DATA !== held) begin errors++; $display("FAIL flush_full got=%b/%b/%b/%h exp=0/0/0/%h", b0.OVERFLOW, b0.FULL, b0.RD_VALID, b0.RD_DATA, held); end
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    checks++; if (b0.UNDERFLOW !== 1'b1 || b0.COUNT !== 4'd0) begin errors++; $display("FAIL flush_then_rd got=%b/%0d exp=1/0", b0.UNDERFLOW, b0.COUNT); end
  endtask

  task automatic test_random();
    int sz;
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 31) == 0, $urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 2) != 0 && n % 50 > 20);
      sz = q.size();
      checks++; if (b0.COUNT !== 4'(sz) || b1.COUNT !== 4'(sz)) begin errors++; $display("FAIL rnd_count n=%0d got=%0d/%0d exp=%0d", n, b0.COUNT, b1.COUNT, sz); end
      checks++; if ({b0.FULL, b0.EMPTY, b0.ALMOST_FULL, b0.ALMOST_EMPTY} !== {sz == 8, sz == 0, sz >= 6, sz <= 2})
        begin errors++; $display("FAIL rnd_flags n=%0d got=%b%b%b%b exp=%b%b%b%b", n, b0.FULL, b0.EMPTY, b0.ALMOST_FULL, b0.ALMOST_EMPTY, sz == 8, sz == 0, sz >= 6, sz <= 2); end
      checks++; if (b0.OVERFLOW !== m_ovf || b0.UNDERFLOW !== m_udf) begin errors++; $display("FAIL rnd_err n=%0d got=%b%b exp=%b%b", n, b0.OVERFLOW, b0.UNDERFLOW, m_ovf, m_udf); end
      checks++; if (b0.RD_VALID !== m_v0 || b0.RD_DATA !== m_rd0) begin errors++; $display("FAIL rnd_reg n=%0d got=%b/%h exp=%b/%h", n, b0.RD_VALID, b0.RD_DATA, m_v0, m_rd0); end
      checks++; if (b1.RD_VALID !== (sz != 0) || (sz != 0 && b1.RD_DATA !== q[0])) begin errors++; $display("FAIL rnd_fwft n=%0d got=%b/%h exp=%b", n, b1.RD_VALID, b1.RD_DATA, sz != 0); end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'($urandom), 1'b0);
    cycle(1'b0, 1'b1, 8'h11, 1'b1);
    wr = 1'b1; wd = 8'h22; rd = 1'b1;
    #3;
    rst = 1'b0;
    #1;
    checks++; if (b0.COUNT !== 4'd0 || b0.EMPTY !== 1'b1 || b0.FULL !== 1'b0) begin errors++; $display("FAIL arst_count got=%0d/%b/%b exp=0/1/0", b0.COUNT, b0.EMPTY, b0.FULL); end
    checks++; if (b0.ALMOST_EMPTY !== 1'b1 || b0.ALMOST_FULL !== 1'b0) begin errors++; $display("FAIL arst_almost got=%b/%b exp=1/0", b0.ALMOST_EMPTY, b0.ALMOST_FULL); end
    checks++; if (b0.RD_VALID !== 1'b0 || b0.RD_DATA !== 8'h00 || b1.RD_VALID !== 1'b0) begin errors++; $display("FAIL arst_rd got=%b/%h/%b exp=0/00/0", b0.RD_VALID, b0.RD_DATA, b1.RD_VALID); end
    @(negedge clk);
    wr = 1'b0; rd = 1'b0;
    rst = 1'b1;
    model_reset();
    cycle(1'b0, 1'b1, 8'h3C, 1'b0);
    checks++; if (b0.COUNT !== 4'd1 || b1.RD_DATA !== 8'h3C) begin errors++; $display("FAIL arst_resume got=%0d/%h exp=1/3c", b0.COUNT, b1.RD_DATA); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain_registered();
    test_fwft();
    test_simultaneous();
    test_wrap();
    test_flush();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
